// File: rtl/jump_pkg.sv
// Shared definitions for the branch-resolution unit: opcodes, default widths, FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package jump_pkg;

    // Default geometry; the top and interface take these as parameter defaults.
    localparam int DEF_PC_W      = 9;
    localparam int DEF_INSTR_W   = 9;
    localparam int DEF_LUT_DEPTH = 32;
    localparam int DEF_RAS_DEPTH = 4;

    // Control-flow opcodes live in instr[8:5].
    localparam logic [3:0] OP_JMP  = 4'b1100;
    localparam logic [3:0] OP_RET  = 4'b1101;
    localparam logic [3:0] OP_BRZ  = 4'b1110;
    localparam logic [3:0] OP_CALL = 4'b1111;

    typedef enum logic {
        RUN      = 1'b0,
        REDIRECT = 1'b1
    } state_t;

endpackage

// File: rtl/jump_ctrl_if.sv
// Bundle between fetch/PC logic and the branch-resolution unit.
// Latency: n/a (wires only).
// Backpressure: none; signals are sampled every cycle.
// Ports: prog_ctr/instr/zero_flag carry the fetched instruction, lut_wr_* load the
// jump LUT, absjump_en/target/flush steer the PC, ras_* are sticky error flags.
interface jump_ctrl_if
    import jump_pkg::*;
#(
    parameter int PC_W    = DEF_PC_W,
    parameter int INSTR_W = DEF_INSTR_W,
    parameter int LUT_AW  = $clog2(DEF_LUT_DEPTH)
);
    logic [PC_W-1:0]    prog_ctr;
    logic [INSTR_W-1:0] instr;
    logic               zero_flag;
    logic               lut_wr_en;
    logic [LUT_AW-1:0]  lut_wr_addr;
    logic [PC_W-1:0]    lut_wr_data;
    logic               absjump_en;
    logic [PC_W-1:0]    target;
    logic               flush;
    logic               ras_overflow;
    logic               ras_underflow;

    // Fetch side drives the instruction stream and LUT writes.
    modport master (
        output prog_ctr, instr, zero_flag, lut_wr_en, lut_wr_addr, lut_wr_data,
        input  absjump_en, target, flush, ras_overflow, ras_underflow
    );

    // Branch unit side.
    modport slave (
        input  prog_ctr, instr, zero_flag, lut_wr_en, lut_wr_addr, lut_wr_data,
        output absjump_en, target, flush, ras_overflow, ras_underflow
    );

endinterface

// File: rtl/ret_stack.sv
// Return-address LIFO: push/pop with full/empty status; top is the most recent entry.
// Latency: push/pop take effect at the next posedge; top is combinational from state.
// Backpressure: push while full and pop while empty are silently dropped.
// Ports: clk, reset (async active-high), push/push_data, pop, top, full, empty.
module ret_stack #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] top,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]    count;
    logic [AW-1:0]    top_idx;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign top_idx = AW'(count - CW'(1));
    assign top     = empty ? '0 : mem[top_idx];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push && !full) begin
            // Push wins over a simultaneous pop; the top never issues both.
            mem[AW'(count)] <= push_data;
            count           <= count + CW'(1);
        end else if (pop && !empty) begin
            count <= count - CW'(1);
        end
    end

endmodule

// File: rtl/jump_ctrl.sv
// Branch-resolution unit: decodes JMP/BRZ/CALL/RET, resolves targets via a jump LUT and RAS.
// Latency: jump decoded in cycle n -> absjump_en/target registered for cycle n+1; flush marks
// the single wrong-path instruction in that cycle. Backpressure: none, one instruction per cycle.
// Ports: clk, reset (async active-high), bus (jump_ctrl_if.slave) carrying fetch, LUT write,
// PC redirect and sticky RAS error flags.
module jump_ctrl
    import jump_pkg::*;
#(
    parameter int PC_W      = DEF_PC_W,
    parameter int INSTR_W   = DEF_INSTR_W,
    parameter int LUT_DEPTH = DEF_LUT_DEPTH,
    parameter int RAS_DEPTH = DEF_RAS_DEPTH
) (
    input  logic        clk,
    input  logic        reset,
    jump_ctrl_if.slave  bus
);
    localparam int LUT_AW = $clog2(LUT_DEPTH);

    state_t            state;
    logic [PC_W-1:0]   lut [LUT_DEPTH];
    logic              absjump_q;
    logic [PC_W-1:0]   target_q;
    logic              ovf_q;
    logic              unf_q;

    logic [3:0]        op;
    logic [LUT_AW-1:0] idx;

    logic              take;
    logic [PC_W-1:0]   jmp_tgt;
    logic              do_push;
    logic              do_pop;
    logic              set_ovf;
    logic              set_unf;

    logic [PC_W-1:0]   ras_top;
    logic              ras_full;
    logic              ras_empty;
    logic [PC_W-1:0]   ret_addr;

    assign op  = bus.instr[INSTR_W-1 -: 4];
    assign idx = bus.instr[LUT_AW-1:0];

    // Return address wraps naturally at PC_W bits (CALL at the last address returns to 0).
    assign ret_addr = bus.prog_ctr + PC_W'(1);

    ret_stack #(
        .DEPTH (RAS_DEPTH),
        .WIDTH (PC_W)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (do_push),
        .push_data (ret_addr),
        .pop       (do_pop),
        .top       (ras_top),
        .full      (ras_full),
        .empty     (ras_empty)
    );

    // Decode only in RUN; the instruction seen during REDIRECT is the wrong-path fetch
    // and must not touch the stack or the flags.
    always_comb begin
        take    = 1'b0;
        jmp_tgt = lut[idx];
        do_push = 1'b0;
        do_pop  = 1'b0;
        set_ovf = 1'b0;
        set_unf = 1'b0;
        if (state == RUN) begin
            case (op)
                OP_JMP: take = 1'b1;
                OP_BRZ: take = bus.zero_flag;
                OP_CALL: begin
                    // A full stack loses the return address but the call still jumps.
                    take    = 1'b1;
                    do_push = !ras_full;
                    set_ovf = ras_full;
                end
                OP_RET: begin
                    if (ras_empty) begin
                        set_unf = 1'b1;
                    end else begin
                        take    = 1'b1;
                        do_pop  = 1'b1;
                        jmp_tgt = ras_top;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= RUN;
            absjump_q <= 1'b0;
            target_q  <= '0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else begin
            if (set_ovf) ovf_q <= 1'b1;
            if (set_unf) unf_q <= 1'b1;
            case (state)
                RUN: begin
                    absjump_q <= take;
                    if (take) begin
                        target_q <= jmp_tgt;
                        state    <= REDIRECT;
                    end
                end
                REDIRECT: begin
                    absjump_q <= 1'b0;
                    state     <= RUN;
                end
                default: begin
                    absjump_q <= 1'b0;
                    state     <= RUN;
                end
            endcase
        end
    end

    // Write lands at the edge, so a same-cycle decode of that index still sees the old entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LUT_DEPTH; i++) begin
                lut[i] <= '0;
            end
        end else if (bus.lut_wr_en) begin
            lut[bus.lut_wr_addr] <= bus.lut_wr_data;
        end
    end

    assign bus.absjump_en    = absjump_q;
    assign bus.target        = target_q;
    assign bus.flush         = (state == REDIRECT);
    assign bus.ras_overflow  = ovf_q;
    assign bus.ras_underflow = unf_q;

endmodule
